// File: rtl/axi_enhanced_rx_port_demux.sv
// axi_enhanced_rx_port_demux: steers RX AXI-Stream TLPs to CR/RC/CFG ports by header type.
// Optional macro AXI_ENHANCED_RX_DROP_CNT_EN builds a saturating counter of TLPs dropped on link down.
module axi_enhanced_rx_port_demux #(
    parameter int C_DATA_WIDTH = 64,
    parameter int TCQ = 1,
    parameter int STRB_WIDTH = C_DATA_WIDTH / 8
) (
    input  logic                    com_iclk,
    input  logic                    com_sysrst,
    input  logic                    trn_lnk_up,
    input  logic [C_DATA_WIDTH-1:0] m_axis_rx_tdata,
    input  logic                    m_axis_rx_tvalid,
    input  logic [STRB_WIDTH-1:0]   m_axis_rx_tstrb,
    input  logic                    m_axis_rx_tlast,
    input  logic [21:0]             m_axis_rx_tuser,
    output logic                    m_axis_rx_tready,
    output logic [C_DATA_WIDTH-1:0] m_axis_cr_tdata,
    output logic                    m_axis_cr_tvalid,
    output logic [STRB_WIDTH-1:0]   m_axis_cr_tstrb,
    output logic                    m_axis_cr_tlast,
    output logic [21:0]             m_axis_cr_tuser,
    input  logic                    m_axis_cr_tready,
    output logic [C_DATA_WIDTH-1:0] m_axis_rc_tdata,
    output logic                    m_axis_rc_tvalid,
    output logic [STRB_WIDTH-1:0]   m_axis_rc_tstrb,
    output logic                    m_axis_rc_tlast,
    output logic [21:0]             m_axis_rc_tuser,
    input  logic                    m_axis_rc_tready,
    output logic [C_DATA_WIDTH-1:0] m_axis_cfg_tdata,
    output logic                    m_axis_cfg_tvalid,
    output logic [STRB_WIDTH-1:0]   m_axis_cfg_tstrb,
    output logic                    m_axis_cfg_tlast,
    output logic [21:0]             m_axis_cfg_tuser,
    input  logic                    m_axis_cfg_tready,
    output logic [15:0]             rx_drop_cnt
);
    typedef enum logic [1:0] {IDLE, PKT, FLUSH} state_t;
    typedef enum logic [1:0] {P_CR, P_RC, P_CFG} port_t;

    if (!(C_DATA_WIDTH == 32 || C_DATA_WIDTH == 64 || C_DATA_WIDTH == 128) || TCQ < 0) begin : g_bad_param
        $error("axi_enhanced_rx_port_demux: unsupported C_DATA_WIDTH or TCQ");
    end

    state_t                  state_q, state_d;
    port_t                   port_q, port_d, hdr_port;
    logic                    lnk_up_q, lnk_up_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic [C_DATA_WIDTH-1:0] data_q, data_d;
    logic [STRB_WIDTH-1:0]   strb_q, strb_d;
    logic [21:0]             user_q, user_d;
    logic                    sel_tready, accept, fwd, link_fall;

    // handshake: registered port's ready gates input; link down or flush swallows everything
    always_comb begin
        hdr_port = (m_axis_rx_tdata[28:25] == 4'b0101) ? P_RC :
                   (m_axis_rx_tdata[28:25] == 4'b0010) ? P_CFG : P_CR;
        sel_tready = (port_q == P_RC) ? m_axis_rc_tready :
                     (port_q == P_CFG) ? m_axis_cfg_tready : m_axis_cr_tready;
        m_axis_rx_tready = !com_sysrst && (state_q == FLUSH || !trn_lnk_up || !valid_q || sel_tready);
        accept = m_axis_rx_tvalid && m_axis_rx_tready;
        fwd = accept && trn_lnk_up && state_q != FLUSH;
        link_fall = lnk_up_q && !trn_lnk_up;
    end

    // packet framing: lock port after the first beat, flush the remainder of a TLP cut by link down
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !m_axis_rx_tlast) state_d = trn_lnk_up ? PKT : FLUSH;
            PKT:     if (accept && m_axis_rx_tlast) state_d = IDLE;
                     else if (!trn_lnk_up) state_d = FLUSH;
            FLUSH:   if (accept && m_axis_rx_tlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // shared output stage: load on forward, drain on ready, discard a partial beat on link down
    always_comb begin
        lnk_up_d = trn_lnk_up;
        port_d = fwd ? ((state_q == IDLE) ? hdr_port : port_q) : port_q;
        valid_d = fwd || (valid_q && !sel_tready && !(link_fall && !last_q));
        data_d = fwd ? m_axis_rx_tdata : data_q;
        strb_d = fwd ? m_axis_rx_tstrb : strb_q;
        last_d = fwd ? m_axis_rx_tlast : last_q;
        user_d = fwd ? m_axis_rx_tuser : user_q;
    end

    // state and output registers
    always_ff @(posedge com_iclk) begin
        if (com_sysrst) begin
            state_q  <= IDLE;
            port_q   <= P_CR;
            lnk_up_q <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
            strb_q   <= '0;
            user_q   <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            lnk_up_q <= lnk_up_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            data_q   <= data_d;
            strb_q   <= strb_d;
            user_q   <= user_d;
        end
    end

    assign m_axis_cr_tdata   = data_q;
    assign m_axis_cr_tstrb   = strb_q;
    assign m_axis_cr_tlast   = last_q;
    assign m_axis_cr_tuser   = user_q;
    assign m_axis_cr_tvalid  = valid_q && port_q == P_CR;
    assign m_axis_rc_tdata   = data_q;
    assign m_axis_rc_tstrb   = strb_q;
    assign m_axis_rc_tlast   = last_q;
    assign m_axis_rc_tuser   = user_q;
    assign m_axis_rc_tvalid  = valid_q && port_q == P_RC;
    assign m_axis_cfg_tdata  = data_q;
    assign m_axis_cfg_tstrb  = strb_q;
    assign m_axis_cfg_tlast  = last_q;
    assign m_axis_cfg_tuser  = user_q;
    assign m_axis_cfg_tvalid = valid_q && port_q == P_CFG;

`ifdef AXI_ENHANCED_RX_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // one drop per TLP cut mid-packet or arriving while the link is down, saturating
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (((state_q == PKT && !trn_lnk_up) || (state_q == IDLE && accept && !trn_lnk_up)) && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // drop counter register
    always_ff @(posedge com_iclk) begin
        if (com_sysrst) drop_cnt_q <= '0;
        else drop_cnt_q <= drop_cnt_d;
    end

    assign rx_drop_cnt = drop_cnt_q;
`else
    assign rx_drop_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_axi_enhanced_rx_port_demux.sv
// tb_axi_enhanced_rx_port_demux: steering table, directed corner sequences and randomized scoreboard run.
module tb_axi_enhanced_rx_port_demux;
    localparam int DW = 64;
    localparam int SW = DW / 8;
`ifdef AXI_ENHANCED_RX_DROP_CNT_EN
    localparam int DROP_INC = 1;
`else
    localparam int DROP_INC = 0;
`endif

    logic          com_iclk = 1'b0;
    logic          com_sysrst, trn_lnk_up;
    logic [DW-1:0] rx_tdata;
    logic          rx_tvalid, rx_tlast, rx_tready;
    logic [SW-1:0] rx_tstrb;
    logic [21:0]   rx_tuser;
    logic [DW-1:0] cr_tdata, rc_tdata, cfg_tdata;
    logic          cr_tvalid, rc_tvalid, cfg_tvalid;
    logic [SW-1:0] cr_tstrb, rc_tstrb, cfg_tstrb;
    logic          cr_tlast, rc_tlast, cfg_tlast;
    logic [21:0]   cr_tuser, rc_tuser, cfg_tuser;
    logic          cr_tready, rc_tready, cfg_tready;
    logic [15:0]   drop_cnt;
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        logic [31:0] dw0;
        logic [2:0]  exp_v;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [21:0]   user;
        logic          last;
        int            port;
    } beat_t;

    vec_t  vecs[12];
    beat_t in_q[$];
    beat_t exp_q[$];

    always #5 com_iclk = ~com_iclk;

    axi_enhanced_rx_port_demux #(.C_DATA_WIDTH(DW)) dut (
        .com_iclk(com_iclk), .com_sysrst(com_sysrst), .trn_lnk_up(trn_lnk_up),
        .m_axis_rx_tdata(rx_tdata), .m_axis_rx_tvalid(rx_tvalid), .m_axis_rx_tstrb(rx_tstrb),
        .m_axis_rx_tlast(rx_tlast), .m_axis_rx_tuser(rx_tuser), .m_axis_rx_tready(rx_tready),
        .m_axis_cr_tdata(cr_tdata), .m_axis_cr_tvalid(cr_tvalid), .m_axis_cr_tstrb(cr_tstrb),
        .m_axis_cr_tlast(cr_tlast), .m_axis_cr_tuser(cr_tuser), .m_axis_cr_tready(cr_tready),
        .m_axis_rc_tdata(rc_tdata), .m_axis_rc_tvalid(rc_tvalid), .m_axis_rc_tstrb(rc_tstrb),
        .m_axis_rc_tlast(rc_tlast), .m_axis_rc_tuser(rc_tuser), .m_axis_rc_tready(rc_tready),
        .m_axis_cfg_tdata(cfg_tdata), .m_axis_cfg_tvalid(cfg_tvalid), .m_axis_cfg_tstrb(cfg_tstrb),
        .m_axis_cfg_tlast(cfg_tlast), .m_axis_cfg_tuser(cfg_tuser), .m_axis_cfg_tready(cfg_tready),
        .rx_drop_cnt(drop_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge com_iclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic l);
        rx_tvalid = v;
        rx_tdata  = d;
        rx_tlast  = l;
        rx_tstrb  = d[SW+39:40];
        rx_tuser  = d[53:32];
    endtask

    function automatic int exp_port(input logic [4:0] t);
        if (t == 5'b01010 || t == 5'b01011) return 1;
        if (t == 5'b00100 || t == 5'b00101) return 2;
        return 0;
    endfunction

    function automatic logic [2:0] valids();
        return {cfg_tvalid, rc_tvalid, cr_tvalid};
    endfunction

    initial begin
        logic [DW-1:0] b[4];
        logic [2:0]    ov, orr;
        logic [4:0]    types[7];
        bit            pending;
        int            p;
        beat_t         e, nb;

        vecs[0]  = '{32'h40000001, 3'b001};
        vecs[1]  = '{32'h4A000001, 3'b010};
        vecs[2]  = '{32'h0A000001, 3'b010};
        vecs[3]  = '{32'h0B000001, 3'b010};
        vecs[4]  = '{32'h04000001, 3'b100};
        vecs[5]  = '{32'h45000001, 3'b100};
        vecs[6]  = '{32'h09000001, 3'b001};
        vecs[7]  = '{32'h0C000001, 3'b001};
        vecs[8]  = '{32'h06000001, 3'b001};
        vecs[9]  = '{32'h03000001, 3'b001};
        vecs[10] = '{32'h7A000001, 3'b001};
        vecs[11] = '{32'hE4FFFFFF, 3'b100};

        com_sysrst = 1'b1;
        trn_lnk_up = 1'b1;
        cr_tready  = 1'b1;
        rc_tready  = 1'b1;
        cfg_tready = 1'b1;
        drive(1'b0, '0, 1'b0);
        tick();
        tick();
        @(negedge com_iclk);
        chk("reset_rx_tready", rx_tready, 0);
        chk("reset_valids", valids(), 0);
        chk("reset_tdata", cr_tdata, 0);
        chk("reset_tuser", cfg_tuser, 0);
        chk("reset_drop_cnt", drop_cnt, 0);
        tick();
        com_sysrst = 1'b0;
        @(negedge com_iclk);
        chk("post_reset_rx_tready", rx_tready, 1);

        // steering table: one single-beat TLP per vector
        for (int i = 0; i < 12; i++) begin
            tick();
            drive(1'b1, {32'hA5A50000 ^ i, vecs[i].dw0}, 1'b1);
            @(negedge com_iclk);
            chk($sformatf("steer%0d_accept", i), rx_tready, 1);
            tick();
            drive(1'b0, '0, 1'b0);
            @(negedge com_iclk);
            chk($sformatf("steer%0d_valids", i), valids(), vecs[i].exp_v);
            chk($sformatf("steer%0d_tdata", i), cr_tdata, {32'hA5A50000 ^ i, vecs[i].dw0});
        end

        // two-beat MWr to CR
        b[0] = {32'h11112222, 32'h40000001};
        b[1] = 64'h3333444455556666;
        tick();
        drive(1'b1, b[0], 1'b0);
        @(negedge com_iclk);
        chk("mwr_accept", rx_tready, 1);
        tick();
        drive(1'b1, b[1], 1'b1);
        @(negedge com_iclk);
        chk("mwr_b1_valids", valids(), 3'b001);
        chk("mwr_b1_tlast", cr_tlast, 0);
        chk("mwr_b1_tdata", cr_tdata, b[0]);
        tick();
        drive(1'b0, '0, 1'b0);
        @(negedge com_iclk);
        chk("mwr_b2_valids", valids(), 3'b001);
        chk("mwr_b2_tlast", cr_tlast, 1);
        chk("mwr_b2_tdata", cr_tdata, b[1]);
        tick();
        @(negedge com_iclk);
        chk("mwr_done_valids", valids(), 0);

        // back-to-back CplD then CfgRd0 with no bubble
        tick();
        drive(1'b1, {32'h0, 32'h4A000001}, 1'b1);
        @(negedge com_iclk);
        tick();
        drive(1'b1, {32'h0, 32'h04000001}, 1'b1);
        @(negedge com_iclk);
        chk("b2b_rc_valids", valids(), 3'b010);
        chk("b2b_cfg_accept", rx_tready, 1);
        tick();
        drive(1'b0, '0, 1'b0);
        @(negedge com_iclk);
        chk("b2b_cfg_valids", valids(), 3'b100);
        tick();
        @(negedge com_iclk);
        chk("b2b_idle_valids", valids(), 0);

        // RC backpressure for three cycles mid-completion
        b[0] = {32'hC0DE0001, 32'h4A000004};
        b[1] = 64'hC0DE0002_00000002;
        b[2] = 64'hC0DE0003_00000003;
        b[3] = 64'hC0DE0004_00000004;
        tick();
        drive(1'b1, b[0], 1'b0);
        @(negedge com_iclk);
        for (int k = 0; k < 3; k++) begin
            tick();
            rc_tready = 1'b0;
            drive(1'b1, b[1], 1'b0);
            @(negedge com_iclk);
            chk($sformatf("bp%0d_rx_tready", k), rx_tready, 0);
            chk($sformatf("bp%0d_rc_tvalid", k), rc_tvalid, 1);
            chk($sformatf("bp%0d_rc_tdata", k), rc_tdata, b[0]);
        end
        tick();
        rc_tready = 1'b1;
        @(negedge com_iclk);
        chk("bp_release_rx_tready", rx_tready, 1);
        chk("bp_release_rc_tdata", rc_tdata, b[0]);
        for (int k = 2; k <= 4; k++) begin
            tick();
            if (k < 4) drive(1'b1, b[k], k == 3);
            else drive(1'b0, '0, 1'b0);
            @(negedge com_iclk);
            chk($sformatf("bp_beat%0d_rc_tdata", k - 1), rc_tdata, b[k-1]);
            chk($sformatf("bp_beat%0d_rc_tlast", k - 1), rc_tlast, k == 4);
        end
        tick();
        @(negedge com_iclk);
        chk("bp_done_valids", valids(), 0);

        // link down after beat 1 of a 4-beat MRd, then a TLP arriving while link is down
        tick();
        drive(1'b1, {32'hD00D0001, 32'h00000001}, 1'b0);
        @(negedge com_iclk);
        tick();
        trn_lnk_up = 1'b0;
        cr_tready = 1'b0;
        drive(1'b1, 64'hD00D0002, 1'b0);
        @(negedge com_iclk);
        chk("flush_b2_rx_tready", rx_tready, 1);
        tick();
        cr_tready = 1'b1;
        drive(1'b1, 64'hD00D0003, 1'b0);
        @(negedge com_iclk);
        chk("flush_b3_valids", valids(), 0);
        chk("flush_b3_rx_tready", rx_tready, 1);
        tick();
        drive(1'b1, 64'hD00D0004, 1'b1);
        @(negedge com_iclk);
        chk("flush_b4_valids", valids(), 0);
        tick();
        drive(1'b0, '0, 1'b0);
        @(negedge com_iclk);
        chk("flush_done_valids", valids(), 0);
        chk("flush_drop_cnt", drop_cnt, DROP_INC);
        tick();
        drive(1'b1, {32'h0, 32'h4A000001}, 1'b1);
        @(negedge com_iclk);
        chk("lnkdn_rx_tready", rx_tready, 1);
        tick();
        drive(1'b0, '0, 1'b0);
        @(negedge com_iclk);
        chk("lnkdn_valids", valids(), 0);
        chk("lnkdn_drop_cnt", drop_cnt, 2 * DROP_INC);
        tick();
        trn_lnk_up = 1'b1;
        tick();
        drive(1'b1, {32'h0, 32'h40000001}, 1'b1);
        @(negedge com_iclk);
        tick();
        drive(1'b0, '0, 1'b0);
        @(negedge com_iclk);
        chk("relink_valids", valids(), 3'b001);

        // reset mid-packet, next TLP steered from its own first beat
        tick();
        drive(1'b1, {32'hBEEF0001, 32'h40000001}, 1'b0);
        @(negedge com_iclk);
        tick();
        com_sysrst = 1'b1;
        drive(1'b1, 64'hBEEF0002, 1'b0);
        @(negedge com_iclk);
        chk("rst_mid_rx_tready", rx_tready, 0);
        tick();
        com_sysrst = 1'b0;
        drive(1'b1, {32'hBEEF0003, 32'h4A000001}, 1'b1);
        @(negedge com_iclk);
        chk("rst_mid_valids", valids(), 0);
        chk("rst_mid_drop_cnt", drop_cnt, 0);
        chk("rst_mid_accept", rx_tready, 1);
        tick();
        drive(1'b0, '0, 1'b0);
        @(negedge com_iclk);
        chk("rst_next_valids", valids(), 3'b010);
        chk("rst_next_tdata", rc_tdata, {32'hBEEF0003, 32'h4A000001});

        // randomized traffic against a FIFO scoreboard with spec steering rules
        types = '{5'b00000, 5'b00010, 5'b01010, 5'b01011, 5'b00100, 5'b00101, 5'b11111};
        for (int n = 0; n < 300; n++) begin
            int len = $urandom_range(1, 4);
            logic [4:0] t = types[$urandom_range(0, 6)];
            if (t == 5'b11111) t = 5'($urandom);
            for (int k = 0; k < len; k++) begin
                nb.data = {$urandom, $urandom};
                if (k == 0) nb.data[30:24] = {2'($urandom), t};
                nb.strb = 8'($urandom);
                nb.user = 22'($urandom);
                nb.last = (k == len - 1);
                nb.port = exp_port(t);
                in_q.push_back(nb);
            end
        end
        tick();
        drive(1'b0, '0, 1'b0);
        pending = 1'b0;
        for (int c = 0; c < 20000 && (in_q.size() > 0 || exp_q.size() > 0); c++) begin
            cr_tready  = $urandom_range(0, 3) != 0;
            rc_tready  = $urandom_range(0, 3) != 0;
            cfg_tready = $urandom_range(0, 3) != 0;
            if (!pending) begin
                rx_tvalid = 1'b0;
                if (in_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    rx_tvalid = 1'b1;
                    rx_tdata  = in_q[0].data;
                    rx_tstrb  = in_q[0].strb;
                    rx_tuser  = in_q[0].user;
                    rx_tlast  = in_q[0].last;
                end
            end
            @(negedge com_iclk);
            ov  = valids();
            orr = {cfg_tready, rc_tready, cr_tready};
            chk("rand_onehot", $countones(ov) <= 1, 1);
            if ((ov & orr) != 0) begin
                p = ov[0] ? 0 : ov[1] ? 1 : 2;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_unexpected: got beat on port %0d expected none", p);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_port", p, e.port);
                    chk("rand_tdata", p == 0 ? cr_tdata : p == 1 ? rc_tdata : cfg_tdata, e.data);
                    chk("rand_tstrb", p == 0 ? cr_tstrb : p == 1 ? rc_tstrb : cfg_tstrb, e.strb);
                    chk("rand_tuser", p == 0 ? cr_tuser : p == 1 ? rc_tuser : cfg_tuser, e.user);
                    chk("rand_tlast", p == 0 ? cr_tlast : p == 1 ? rc_tlast : cfg_tlast, e.last);
                end
            end
            if (rx_tvalid && rx_tready) begin
                exp_q.push_back(in_q.pop_front());
                pending = 1'b0;
            end else begin
                pending = rx_tvalid;
            end
            tick();
        end
        chk("rand_input_drained", in_q.size(), 0);
        chk("rand_output_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
